refclk_out_gen: RTL and testbench



---
 rtl/refclk_out_gen.sv | 184 ++++++++++++++++++
 tb/tb_refclk_out_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/refclk_out_gen.sv
// ============================================================================
// Module      : refclk_out_gen
// Description : Multi-channel forwarded-clock generator producing registered
//               DDR bit pairs with a programmable 50% duty period of N cycles.
//               Optional macro REFCLK_OUT_GEN_SYNC_START_EN adds an ARMED state
//               and a sync_start input for phase-aligned channel starts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module refclk_out_gen #(
  parameter int CHANNELS  = 2,
  parameter int DIV_WIDTH = 8
) (
  input  logic                                            clk_50mhz,
  input  logic                                            rst_n,
`ifdef REFCLK_OUT_GEN_SYNC_START_EN
  input  logic                                            sync_start,
`endif
  input  logic                                            cfg_wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [DIV_WIDTH-1:0]                            cfg_div,
  input  logic                                            cfg_enable,
  output logic [CHANNELS-1:0]                             ddr_din0,
  output logic [CHANNELS-1:0]                             ddr_din1,
  output logic [CHANNELS-1:0]                             running
);

  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PH_W   = DIV_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2,
    ST_ARMED    = 2'd3
  } state_t;

  // Half-cycle h of a period of n cycles is high once h reaches n.
  function automatic logic half_bit(input logic [PH_W-1:0] h,
                                    input logic [DIV_WIDTH-1:0] n);
    return (h >= {1'b0, n});
  endfunction

`ifdef REFCLK_OUT_GEN_SYNC_START_EN
  logic r_sync_start;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_start <= 1'b0;
    end else begin
      r_sync_start <= sync_start;
    end
  end
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    state_t               r_state;
    state_t               w_state_nxt;
    logic [PH_W-1:0]      r_ph;
    logic [PH_W-1:0]      w_ph_nxt;
    logic [PH_W-1:0]      w_ph_last;
    logic [PH_W-1:0]      w_ph_adv;
    logic [DIV_WIDTH-1:0] r_active_div;
    logic [DIV_WIDTH-1:0] w_active_div_nxt;
    logic [DIV_WIDTH-1:0] r_pending_div;
    logic                 r_pending_en;
    logic                 r_din0;
    logic                 r_din1;
    logic                 r_running;
    logic                 w_din0_nxt;
    logic                 w_din1_nxt;
    logic                 w_running_nxt;
    logic                 w_wr_hit;
    logic                 w_wrap;
    logic                 w_start;

    // Out-of-range channel indices never match any g, so they are dropped.
    assign w_wr_hit = cfg_wr_en && (cfg_chan == CHAN_W'(g));

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
        r_pending_div <= DIV_WIDTH'(1);
        r_pending_en  <= 1'b0;
      end else if (w_wr_hit) begin
        r_pending_div <= (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
        r_pending_en  <= cfg_enable;
      end
    end

    assign w_ph_last = {r_active_div, 1'b0} - PH_W'(2);
    assign w_wrap    = (r_ph == w_ph_last);
    assign w_ph_adv  = w_wrap ? '0 : (r_ph + PH_W'(2));

    always_comb begin
      w_state_nxt      = r_state;
      w_ph_nxt         = r_ph;
      w_active_div_nxt = r_active_div;
      w_din0_nxt       = 1'b0;
      w_din1_nxt       = 1'b0;
      w_running_nxt    = 1'b0;
      w_start          = 1'b0;

      case (r_state)
        ST_IDLE: begin
`ifdef REFCLK_OUT_GEN_SYNC_START_EN
          if (r_pending_en) begin
            w_state_nxt = ST_ARMED;
          end
`else
          w_start = r_pending_en;
`endif
        end

        ST_RUN, ST_STOPPING: begin
          // Stopping is only honoured where a new period would begin, so the
          // final high half is always completed.
          if (w_wrap && !r_pending_en) begin
            w_state_nxt = ST_IDLE;
            w_ph_nxt    = '0;
          end else begin
            w_state_nxt = r_pending_en ? ST_RUN : ST_STOPPING;
            w_ph_nxt    = w_ph_adv;
            if (w_wrap) begin
              w_active_div_nxt = r_pending_div;
            end
            w_din0_nxt    = half_bit(w_ph_nxt, w_active_div_nxt);
            w_din1_nxt    = half_bit(w_ph_nxt + PH_W'(1), w_active_div_nxt);
            w_running_nxt = 1'b1;
          end
        end

`ifdef REFCLK_OUT_GEN_SYNC_START_EN
        ST_ARMED: begin
          if (!r_pending_en) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_start = r_sync_start;
          end
        end
`endif

        default: begin
          w_state_nxt = ST_IDLE;
          w_ph_nxt    = '0;
        end
      endcase

      if (w_start) begin
        w_state_nxt      = ST_RUN;
        w_ph_nxt         = '0;
        w_active_div_nxt = r_pending_div;
        w_din0_nxt       = half_bit('0, r_pending_div);
        w_din1_nxt       = half_bit(PH_W'(1), r_pending_div);
        w_running_nxt    = 1'b1;
      end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
        r_state      <= ST_IDLE;
        r_ph         <= '0;
        r_active_div <= DIV_WIDTH'(1);
        r_din0       <= 1'b0;
        r_din1       <= 1'b0;
        r_running    <= 1'b0;
      end else begin
        r_state      <= w_state_nxt;
        r_ph         <= w_ph_nxt;
        r_active_div <= w_active_div_nxt;
        r_din0       <= w_din0_nxt;
        r_din1       <= w_din1_nxt;
        r_running    <= w_running_nxt;
      end
    end

    assign ddr_din0[g] = r_din0;
    assign ddr_din1[g] = r_din1;
    assign running[g]  = r_running;
  end

endmodule

`default_nettype wire

// File: tb/tb_refclk_out_gen.sv
// ============================================================================
// Module      : tb_refclk_out_gen
// Description : Scoreboard bench for refclk_out_gen driven by directed and
//               random configuration writes against a period-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_refclk_out_gen;

  localparam int CHANNELS  = 3;
  localparam int DIV_WIDTH = 8;
  localparam int CHAN_W    = 2;

  logic                 clk_50mhz = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 cfg_wr_en = 1'b0;
  logic                 cfg_enable = 1'b0;
  logic [CHAN_W-1:0]    cfg_chan  = '0;
  logic [DIV_WIDTH-1:0] cfg_div   = '0;
  logic [CHANNELS-1:0]  ddr_din0;
  logic [CHANNELS-1:0]  ddr_din1;
  logic [CHANNELS-1:0]  running;
`ifdef REFCLK_OUT_GEN_SYNC_START_EN
  logic                 sync_start = 1'b0;
`endif

  always #10 clk_50mhz = ~clk_50mhz;

  refclk_out_gen #(
    .CHANNELS  (CHANNELS),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .clk_50mhz  (clk_50mhz),
    .rst_n      (rst_n),
`ifdef REFCLK_OUT_GEN_SYNC_START_EN
    .sync_start (sync_start),
`endif
    .cfg_wr_en  (cfg_wr_en),
    .cfg_chan   (cfg_chan),
    .cfg_div    (cfg_div),
    .cfg_enable (cfg_enable),
    .ddr_din0   (ddr_din0),
    .ddr_din1   (ddr_din1),
    .running    (running)
  );

  typedef struct packed {
    logic [CHANNELS-1:0] d0;
    logic [CHANNELS-1:0] d1;
    logic [CHANNELS-1:0] run;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Period-level model: a channel is active or not, sits at cycle k of an
  // N-cycle period, and only looks at its pending settings at period starts.
  int m_pdiv [CHANNELS];
  bit m_pen  [CHANNELS];
  bit m_act  [CHANNELS];
  int m_n    [CHANNELS];
  int m_k    [CHANNELS];

  always @(posedge clk_50mhz) begin
    exp_t e;
    e = '0;
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        m_pdiv[c] = 1;
        m_pen[c]  = 1'b0;
        m_act[c]  = 1'b0;
        m_n[c]    = 1;
        m_k[c]    = 0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!m_act[c]) begin
          if (m_pen[c]) begin
            m_act[c] = 1'b1;
            m_n[c]   = m_pdiv[c];
            m_k[c]   = 0;
          end
        end else begin
          m_k[c] = (m_k[c] + 1) % m_n[c];
          if (m_k[c] == 0) begin
            if (!m_pen[c]) m_act[c] = 1'b0;
            else           m_n[c]   = m_pdiv[c];
          end
        end
        if (m_act[c]) begin
          e.d0[c]  = (2 * m_k[c] >= m_n[c]);
          e.d1[c]  = (2 * m_k[c] + 1 >= m_n[c]);
          e.run[c] = 1'b1;
        end
      end
      if (cfg_wr_en && int'(cfg_chan) < CHANNELS) begin
        m_pdiv[int'(cfg_chan)] = (cfg_div == '0) ? 1 : int'(cfg_div);
        m_pen[int'(cfg_chan)]  = cfg_enable;
      end
    end
    exp_q.push_back(e);
  end

  always @(negedge clk_50mhz) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (ddr_din0 !== e.d0 || ddr_din1 !== e.d1 || running !== e.run) begin
        errors++;
        $display("FAIL pair_check t=%0t: got din0=%b din1=%b running=%b, expected din0=%b din1=%b running=%b",
                 $time, ddr_din0, ddr_din1, running, e.d0, e.d1, e.run);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_50mhz);
      #1;
    end
  endtask

  task automatic wr(input int ch, input int div, input bit en);
    cfg_wr_en  = 1'b1;
    cfg_chan   = CHAN_W'(ch);
    cfg_div    = DIV_WIDTH'(div);
    cfg_enable = en;
    @(posedge clk_50mhz);
    #1;
    cfg_wr_en  = 1'b0;
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Directed walk through the main scenarios.
    wr(0, 1, 1'b1);  idle(6);
    wr(1, 3, 1'b1);  idle(10);
    wr(1, 0, 1'b1);  idle(6);
    wr(0, 4, 1'b1);  idle(6);
    wr(0, 2, 1'b1);  idle(10);
    wr(0, 4, 1'b1);  idle(7);
    wr(0, 4, 1'b0);  idle(8);
    wr(0, 4, 1'b1);  idle(2);
    wr(0, 4, 1'b0);  idle(1);
    wr(0, 4, 1'b1);  idle(8);
    wr(3, 5, 1'b0);  idle(4);
    wr(2, 255, 1'b1); idle(20);
    wr(2, 255, 1'b0); idle(520);

    // Random configuration traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        wr($urandom_range(0, 3),
           ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6),
           ($urandom_range(0, 3) != 0));
      end else begin
        idle(1);
      end
    end

    // Asynchronous reset while ch0 is running at the input rate.
    wr(0, 1, 1'b1);
    idle(4);
    @(negedge clk_50mhz);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ddr_din0 !== '0 || ddr_din1 !== '0 || running !== '0) begin
      errors++;
      $display("FAIL async_reset: got din0=%b din1=%b running=%b, expected all zero",
               ddr_din0, ddr_din1, running);
    end
    idle(2);
    rst_n = 1'b1;
    idle(3);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        wr($urandom_range(0, 3), $urandom_range(0, 5), ($urandom_range(0, 2) != 0));
      end else begin
        idle(1);
      end
    end

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
